// File: rtl/wb_seg7_mux_if.sv
// Wishbone slave bus bundle for the multiplexed 7-segment display peripheral.
interface wb_seg7_mux_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_seg7_mux.sv
// Wishbone slave driving a multiplexed common-anode 7-segment display.
// Define WB_SEG7_BIN2BCD_EN to build the sequential binary-to-BCD converter.
module wb_seg7_mux #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  wb_seg7_mux_if.slave      wb,
  output logic              intr,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [DIGITS-1:0] an_out
);
  localparam int unsigned   DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned   PW     = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(DIGITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

  logic              ack, en, ie, bcd, frame, busy, ovf;
  logic [31:0]       number, number_next, rdata;
  logic [DIGITS-1:0] dp_reg, blank;
  logic [PW-1:0]     pre;
  logic [DW-1:0]     d;
  logic [39:0]       result;
  logic [3:0]        nib;
  logic [6:0]        seg_on;
  logic              req, wr, frame_evt;
  logic              wr_ctrl, wr_status, wr_number, wr_dp, wr_blank;

  // A request is only taken while ack is low, so each access costs two cycles.
  assign req         = wb.wb_stb_i & wb.wb_cyc_i & ~ack;
  assign wr          = req & wb.wb_we_i;
  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack;
  assign intr        = frame & ie;
  assign frame_evt   = en && (pre == P_LAST) && (d == D_LAST);

  assign wr_ctrl   = wr && (wb.wb_adr_i[7:0] == 8'h00);
  assign wr_status = wr && (wb.wb_adr_i[7:0] == 8'h04);
  assign wr_number = wr && (wb.wb_adr_i[7:0] == 8'h10);
  assign wr_dp     = wr && (wb.wb_adr_i[7:0] == 8'h14);
  assign wr_blank  = wr && (wb.wb_adr_i[7:0] == 8'h18);

  always_comb begin
    number_next = number;
    for (int unsigned b = 0; b < 4; b++)
      if (wb.wb_sel_i[b]) number_next[8*b +: 8] = wb.wb_dat_i[8*b +: 8];
  end

  always_comb begin
    rdata = '0;
    case (wb.wb_adr_i[7:0])
      8'h00:   rdata[2:0] = {bcd, ie, en};
      8'h04:   rdata[2:0] = {ovf, busy, frame};
      8'h10:   rdata = number;
      8'h14:   rdata[DIGITS-1:0] = dp_reg;
      8'h18:   rdata[DIGITS-1:0] = blank;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack       <= 1'b0;
      wb.wb_dat_o <= '0;
      en        <= 1'b0;
      ie        <= 1'b0;
      frame     <= 1'b0;
      number    <= '0;
      dp_reg    <= '0;
      blank     <= '0;
      pre       <= '0;
      d         <= '0;
    end else begin
      ack <= req;
      if (req) wb.wb_dat_o <= rdata;
      if (wr_ctrl && wb.wb_sel_i[0]) begin
        en <= wb.wb_dat_i[0];
        ie <= wb.wb_dat_i[1];
      end
      if (wr_number) number <= number_next;
      if (wr_dp && wb.wb_sel_i[0]) dp_reg <= wb.wb_dat_i[DIGITS-1:0];
      if (wr_blank && wb.wb_sel_i[0]) blank <= wb.wb_dat_i[DIGITS-1:0];
      // A frame event beats a simultaneous write-1-to-clear.
      if (frame_evt) frame <= 1'b1;
      else if (wr_status && wb.wb_sel_i[0] && wb.wb_dat_i[0]) frame <= 1'b0;
      if (!en) begin
        pre <= '0;
        d   <= '0;
      end else if (pre == P_LAST) begin
        pre <= '0;
        d   <= (d == D_LAST) ? '0 : d + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  assign nib = bcd ? result[{d, 2'b00} +: 4] : number[{d, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'h0: seg_on = 7'h3F;
      4'h1: seg_on = 7'h06;
      4'h2: seg_on = 7'h5B;
      4'h3: seg_on = 7'h4F;
      4'h4: seg_on = 7'h66;
      4'h5: seg_on = 7'h6D;
      4'h6: seg_on = 7'h7D;
      4'h7: seg_on = 7'h07;
      4'h8: seg_on = 7'h7F;
      4'h9: seg_on = 7'h6F;
      4'hA: seg_on = 7'h77;
      4'hB: seg_on = 7'h7C;
      4'hC: seg_on = 7'h39;
      4'hD: seg_on = 7'h5E;
      4'hE: seg_on = 7'h79;
      default: seg_on = 7'h71;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_out  <= '1;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else if (!en || blank[d]) begin
      an_out  <= '1;
      seg_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= ~(DIGITS'(1) << d);
      seg_out <= ~seg_on;
      dp_out  <= ~dp_reg[d];
    end
  end

`ifdef WB_SEG7_BIN2BCD_EN
  logic [31:0] bin;
  logic [39:0] acc, acc_adj;
  logic [5:0]  step;
  logic        unused;

  assign unused = ^{wb.wb_adr_i[31:8], acc_adj[39]};
  assign ovf    = |(result >> (4 * DIGITS));

  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 10; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // 32 add-3/shift steps, then one commit cycle so the display swaps atomically.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd    <= 1'b0;
      busy   <= 1'b0;
      bin    <= '0;
      acc    <= '0;
      step   <= '0;
      result <= '0;
    end else begin
      if (wr_ctrl && wb.wb_sel_i[0]) bcd <= wb.wb_dat_i[2];
      if (wr_number || (wr_ctrl && wb.wb_sel_i[0] && wb.wb_dat_i[2] && !bcd)) begin
        bin  <= wr_number ? number_next : number;
        acc  <= '0;
        step <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        if (step == 6'd32) begin
          result <= acc;
          busy   <= 1'b0;
        end else begin
          {acc, bin} <= {acc_adj[38:0], bin, 1'b0};
          step       <= step + 1'b1;
        end
      end
    end
  end
`else
  logic unused;

  assign unused = ^wb.wb_adr_i[31:8];
  assign bcd    = 1'b0;
  assign busy   = 1'b0;
  assign ovf    = 1'b0;
  assign result = '0;
`endif
endmodule

// File: tb/tb_wb_seg7_mux.sv
// Scoreboard bench for wb_seg7_mux: bus reads and display scan are checked by monitors.
module tb_wb_seg7_mux;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned TW       = DIGITS + 8;

  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              intr, dp_out;
  logic [6:0]        seg_out;
  logic [DIGITS-1:0] an_out;

  int checks = 0;
  int errors = 0;

  rd_exp_t        rd_q[$];
  logic [TW-1:0]  disp_q[$];
  logic           mon_on = 1'b0;

  wb_seg7_mux_if bus();

  wb_seg7_mux #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .wb(bus),
    .intr(intr), .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=unexpected exp=none", name);
  endfunction

  function automatic logic [TW-1:0] tuple(input int unsigned i, input logic [3:0] n,
                                          input logic dpb, input logic blk);
    logic [DIGITS-1:0] an;
    if (blk) return {{DIGITS{1'b1}}, 7'h7F, 1'b1};
    an    = '1;
    an[i] = 1'b0;
    return {an, ~SEG_ON[n], ~dpb};
  endfunction

  task automatic bus_cycle(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output int lat);
    logic [31:0] r;
    r = $urandom();
    @(negedge clk);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = {r[31:8], adr};
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.wb_ack_o && lat < 8);
    if (!bus.wb_ack_o) fail("ack_timeout");
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    int lat;
    bus_cycle(1'b1, adr, sel, dat, lat);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input logic [31:0] mask,
                    output int lat);
    rd_q.push_back('{data: exp, mask: mask});
    bus_cycle(1'b0, adr, 4'hF, 32'h0, lat);
  endtask

  // Read monitor: every acknowledged read is matched against the oldest expectation.
  always begin
    rd_exp_t e;
    @(posedge clk);
    #1;
    if (bus.wb_ack_o && !bus.wb_we_i) begin
      if (rd_q.size() == 0) fail("read_unexpected");
      else begin
        e = rd_q.pop_front();
        check("read_data", bus.wb_dat_o & e.mask, e.data & e.mask);
      end
    end
  end

  // Display monitor: each change of the displayed digit must match the next expected
  // digit and follow the previous change by exactly SCAN_DIV cycles.
  always begin
    logic [TW-1:0] cur, prev, e;
    int            cyc, last;
    logic          armed;
    cyc = 0; last = -1; armed = 1'b0; prev = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      cur = {an_out, seg_out, dp_out};
      if (!mon_on) armed = 1'b0;
      else if (!armed) begin
        armed = 1'b1;
        prev  = cur;
        last  = -1;
      end else if (cur != prev) begin
        if (disp_q.size() > 0) begin
          e = disp_q.pop_front();
          check("disp_digit", 32'(cur), 32'(e));
          if (last >= 0) check("disp_dwell", 32'(cyc - last), SCAN_DIV);
          last = cyc;
        end
        prev = cur;
      end
    end
  end

  task automatic scan_round(input logic bcdm, input logic [31:0] num);
    logic [3:0]  opts [7] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'hA};
    logic [3:0]  dpv, blk, n;
    logic [31:0] v;
    int          lat;
    dpv = 4'($urandom_range(0, 15));
    blk = opts[$urandom_range(0, 6)];
    wr(8'h00, 4'h1, {29'h0, bcdm, 2'b00});
    wr(8'h10, 4'hF, num);
    wr(8'h14, 4'h1, {28'h0, dpv});
    wr(8'h18, 4'h1, {28'h0, blk});
    rd(8'h10, num, '1, lat);
    rd(8'h14, {28'h0, dpv}, '1, lat);
    rd(8'h18, {28'h0, blk}, '1, lat);
    if (bcdm) repeat (40) @(negedge clk);
    for (int unsigned f = 0; f < 2; f++) begin
      v = num;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        n = bcdm ? 4'(v % 10) : 4'(v & 32'hF);
        v = bcdm ? v / 10 : v >> 4;
        if (!(f == 0 && i == 0 && blk[0])) disp_q.push_back(tuple(i, n, dpv[i], blk[i]));
      end
    end
    mon_on = 1'b1;
    wr(8'h00, 4'h1, {29'h0, bcdm, 2'b01});
    repeat (2 * DIGITS * SCAN_DIV + 12) @(negedge clk);
    check("disp_drained", disp_q.size(), 0);
    disp_q.delete();
    mon_on = 1'b0;
    wr(8'h00, 4'h1, {29'h0, bcdm, 2'b00});
    @(negedge clk);
    check("off_an", 32'(an_out), 32'hF);
    check("off_seg", 32'(seg_out), 32'h7F);
    check("off_dp", 32'(dp_out), 32'h1);
  endtask

  initial begin
    logic [31:0] m_number, dat;
    logic [3:0]  m_dp, m_blank, sel;
    logic [1:0]  m_ctrl;
    int          lat, n, k;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_sel_i = '0;   bus.wb_dat_i = '0;
    #12;
    check("rst_an", 32'(an_out), 32'hF);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_dp", 32'(dp_out), 32'h1);
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(8'h10, 32'h0, '1, lat);
    check("read_latency", lat, 1);
    rd(8'h00, 32'h0, '1, lat);

    // Random register traffic against a register-level model.
    m_number = '0; m_dp = '0; m_blank = '0; m_ctrl = '0;
    for (int unsigned it = 0; it < 12; it++) begin
      dat = $urandom();
      sel = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 4);
      case (k)
        0: begin
          wr(8'h10, sel, dat);
          for (int unsigned b = 0; b < 4; b++) if (sel[b]) m_number[8*b +: 8] = dat[8*b +: 8];
        end
        1: begin wr(8'h14, sel, dat); if (sel[0]) m_dp = dat[3:0]; end
        2: begin wr(8'h18, sel, dat); if (sel[0]) m_blank = dat[3:0]; end
        3: begin wr(8'h00, sel, dat & 32'h3); if (sel[0]) m_ctrl = dat[1:0]; end
        default: begin
          wr(($urandom_range(0, 1) != 0) ? 8'h0C : 8'h1C, sel, dat);
          rd(8'h0C, 32'h0, '1, lat);
        end
      endcase
      rd(8'h10, m_number, '1, lat);
      rd(8'h14, {28'h0, m_dp}, '1, lat);
      rd(8'h18, {28'h0, m_blank}, '1, lat);
      rd(8'h00, {30'h0, m_ctrl}, '1, lat);
    end
    wr(8'h00, 4'h1, 32'h0);

    // Directed pattern, then randomized scans.
    scan_round(1'b0, 32'h0000_1A2F);
    for (int unsigned r = 0; r < 4; r++) scan_round(1'b0, $urandom());

    // Frame interrupt: latency, plain clear, and clear coincident with a frame event.
    wr(8'h04, 4'h1, 32'h1);
    check("intr_idle", 32'(intr), 32'h0);
    wr(8'h00, 4'h1, 32'h3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!intr && n < 40);
    check("frame_latency", n, DIGITS * SCAN_DIV);
    wr(8'h04, 4'h1, 32'h1);
    check("intr_cleared", 32'(intr), 32'h0);
    repeat (DIGITS * SCAN_DIV - 4) @(negedge clk);
    wr(8'h04, 4'h1, 32'h1);
    check("intr_set_wins", 32'(intr), 32'h1);
    rd(8'h04, 32'h1, 32'h1, lat);

`ifdef WB_SEG7_BIN2BCD_EN
    wr(8'h00, 4'h1, 32'h4);
    wr(8'h10, 4'hF, 32'd123456);
    rd(8'h04, 32'h2, 32'h2, lat);
    repeat (40) @(negedge clk);
    rd(8'h04, 32'h4, 32'h6, lat);
    wr(8'h10, 4'hF, 32'd99999999);
    wr(8'h10, 4'hF, 32'd42);
    repeat (40) @(negedge clk);
    rd(8'h04, 32'h0, 32'h6, lat);
    scan_round(1'b1, 32'd42);
    scan_round(1'b1, 32'($urandom_range(0, 9999)));
    wr(8'h00, 4'h1, 32'h0);
`endif

    // Asynchronous reset in the middle of a scan with the interrupt raised.
    wr(8'h00, 4'h1, 32'h3);
    repeat (DIGITS * SCAN_DIV + 6) @(negedge clk);
    wr(8'h10, 4'hF, $urandom());
    check("pre_reset_intr", 32'(intr), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_an", 32'(an_out), 32'hF);
    check("arst_seg", 32'(seg_out), 32'h7F);
    check("arst_dp", 32'(dp_out), 32'h1);
    check("arst_intr", 32'(intr), 32'h0);
    check("arst_dat", bus.wb_dat_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd(8'h00, 32'h0, '1, lat);
    rd(8'h04, 32'h0, '1, lat);
    rd(8'h10, 32'h0, '1, lat);
    repeat (3) @(negedge clk);
    check("reads_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_seg7_mux.md
Name: wb_seg7_mux

Overview:
- Wishbone slave that drives a multiplexed common-anode 7-segment display of DIGITS digits from a 32-bit number register.
- Replaces the single-digit BCD peripheral on the LM32 SoC bus.
- Adds the following over that peripheral:
  - parametrised digit count and scan rate;
  - per-digit blanking and decimal points;
  - display enable;
  - a frame-done interrupt;
  - optional hardware binary-to-BCD conversion.

Parameters:
- DIGITS, 8: number of digits, legal range 1..8. Digit i shows nibble i.
- SCAN_DIV, 50000: clk cycles each digit is lit. Must be at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wb_stb_i  in  1  Wishbone strobe
- wb_cyc_i  in  1  Wishbone cycle
- wb_ack_o  out  1  Wishbone acknowledge
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only bits [7:0] are decoded
- wb_sel_i  in  4  byte selects, honoured on writes
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data (registered)
- intr  out  1  level interrupt, equal to STATUS.frame AND CTRL.ie
- seg_out  out  7  segments a..g on bits 0..6, active-low
- dp_out  out  1  decimal point, active-low
- an_out  out  DIGITS  one-hot digit anodes, active-low

Behaviour:
- Reset is asynchronous, active-low. While reset is low:
  - all registers are 0, ack is 0, wb_dat_o is 0;
  - an_out is all ones, seg_out is 7'h7F, dp_out is 1, intr is 0.
- Bus handshake:
  - ack is registered; wb_ack_o = wb_stb_i & wb_cyc_i & ack.
  - A request with ack low sets ack the next cycle, so latency is one cycle.
  - Back-to-back accesses therefore take two cycles each.
- Register map (adr[7:0]); unmapped reads return 0, unmapped writes are ignored:
  - 0x00 CTRL (rw): bit0 en, bit1 ie, bit2 bcd.
  - 0x04 STATUS: bit0 frame (write-1-to-clear), bit1 busy (ro), bit2 ovf (ro).
  - 0x10 NUMBER (rw, byte-selectable).
  - 0x14 DP (rw, bits [DIGITS-1:0]): decimal point lit for digit i when bit i is 1.
  - 0x18 BLANK (rw, bits [DIGITS-1:0]): digit i is dark when bit i is 1.
- Scan logic:
  - Prescaler counts 0..SCAN_DIV-1 while en=1.
  - At the terminal count, the prescaler returns to 0 and digit index d advances; d wraps from DIGITS-1 to 0.
  - On the wrap, STATUS.frame is set.
  - If a frame event and a clear-write to STATUS.frame occur in the same cycle, the set wins.
- Disable: clearing en resets the prescaler and d to 0 and blanks all outputs. Setting en restarts the scan at digit 0.
- Outputs:
  - Outputs are registered, so they lag the d update by one cycle.
  - an_out[d] is 0 unless BLANK[d]=1.
  - seg_out is the hex decode (0-F) of source nibble d.
  - dp_out = ~DP[d].
  - A blanked digit drives all segments and dp off.
- Source nibble:
  - NUMBER[4d+3:4d] when bcd=0.
  - The internal BCD result register when bcd=1.
- NUMBER bits above 4*DIGITS are stored and read back but are not displayed.

Optional Feature:
- Macro: WB_SEG7_BIN2BCD_EN.
- With the macro defined:
  - Any NUMBER write, or setting bcd from 0 to 1, starts a sequential double-dabble conversion: 32 shift steps, one per cycle.
  - busy=1 during the conversion; it drops, and the 40-bit result commits atomically, 33 cycles after the write is acknowledged.
  - The display keeps the old result until the commit.
  - A NUMBER write during busy restarts the conversion from the new value.
  - ovf=1 when any BCD digit at index DIGITS or above is nonzero; the lower DIGITS digits are still displayed.
  - Reset mid-conversion aborts it and clears the result.
- Without the macro:
  - CTRL.bcd reads 0 and writes to it are ignored.
  - busy=0, ovf=0, and no conversion logic is built.

Test Plan:
- Release reset with no writes -> an_out all ones, seg_out=7'h7F, wb_dat_o=0, intr=0. Read of 0x10 returns 0 with wb_ack_o high one cycle after stb.
- DIGITS=4, SCAN_DIV=4: write NUMBER=0x0000_1A2F and CTRL=1 -> an_out cycles 1110, 1101, 1011, 0111, 4 clk each. seg_out shows F, 2, A, 1. STATUS.frame sets after 16 cycles.
- BLANK=0x2, DP=0x1 -> digit 1 anode stays high; dp_out=0 only while digit 0 is lit.
- CTRL=3: wait for a frame -> intr=1. Write STATUS=1 -> intr=0 next cycle. Clear-write coincident with a frame event -> frame stays 1.
- With WB_SEG7_BIN2BCD_EN, CTRL.bcd=1, DIGITS=8: write 12345678 decimal -> busy for 33 cycles, then digits show 1..8 and ovf=0. Write 4294967295 -> lower digits 94967295 and ovf=1. Mid-conversion write of 42 -> result 42.
- Assert reset mid-scan and mid-conversion -> all outputs return to reset values immediately, without waiting for a clk edge.
